// File: rtl/dma_priority_encoder.sv
// Purpose: DREQ synchroniser plus fixed/rotating priority arbiter feeding the 8237A timing FSM.
// Latency: DREQ pin to VALID_DREQ is SYNC_STAGES+1 clocks; requestReg to VALID_DREQ is 1 clock.
// Backpressure: one grant in flight; new arbitration waits until the current grant completes or is withdrawn.
module dma_priority_encoder #(
    parameter int SYNC_STAGES = 2,
    parameter int NCH         = 4
) (
    input  logic           CLK,
    input  logic           RESET_N,
    input  logic [NCH-1:0] DREQ,
    input  logic [NCH-1:0] maskReg,
    input  logic [NCH-1:0] requestReg,
    input  logic           cmdDisable,
    input  logic           cmdRotate,
    input  logic           cmdDreqLow,
    input  logic           cmdDackHigh,
    input  logic           validDACK,
    input  logic           serviceDone,
    input  logic           EOP_N,
    output logic [NCH-1:0] VALID_DREQ,
    output logic [NCH-1:0] DACK,
    output logic [1:0]     activeCh,
    output logic [NCH-1:0] clrReq
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Synchroniser chain; the last stage is the only one arbitration looks at.
    logic [NCH-1:0] r_sync [SYNC_STAGES];

    // Architectural state.
    state_t         r_state;
    logic [NCH-1:0] r_vdreq;
    logic [NCH-1:0] r_dack;     // one-hot, active-high internally; pin polarity applied at the output
    logic [NCH-1:0] r_clr;
    logic [1:0]     r_active;
    logic [1:0]     r_ptr;

    // Next-state values produced by the combinational half of the FSM.
    state_t         w_state_nxt;
    logic [NCH-1:0] w_vdreq_nxt;
    logic [NCH-1:0] w_dack_nxt;
    logic [NCH-1:0] w_clr_nxt;
    logic [1:0]     w_active_nxt;
    logic [1:0]     w_ptr_nxt;

    // Request terms.
    logic [NCH-1:0] w_dreq_sync;
    logic [NCH-1:0] w_req_raw;   // request ignoring cmdDisable, used to detect withdrawal
    logic [NCH-1:0] w_eff;       // request that may start a new arbitration
    logic [1:0]     w_search;
    logic [1:0]     w_winner;
    logic [NCH-1:0] w_winner_oh;
    logic [NCH-1:0] w_active_oh;

    // Return the first set request found when searching upward from 'start' with wrap-around.
    function automatic logic [1:0] f_pick(input logic [NCH-1:0] req, input logic [1:0] start);
        logic [NCH-1:0] rot;
        logic [1:0]     idx;
        logic [1:0]     off;
        rot = '0;
        idx = '0;
        off = '0;
        // rot[i] is the request that sits i places after the search start
        for (int i = 0; i < NCH; i++) begin
            idx    = start + 2'(i);
            rot[i] = req[idx];
        end
        // Scan downward so the lowest set offset is the one left standing
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = 2'(i);
            end
        end
        return start + off;
    endfunction

    // Shift every DREQ pin through SYNC_STAGES flops before it is used.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= DREQ;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_dreq_sync = r_sync[SYNC_STAGES-1];

    // Software request bits bypass both sense polarity and mask.
    assign w_req_raw   = ((w_dreq_sync ^ {NCH{cmdDreqLow}}) & ~maskReg) | requestReg;
    assign w_eff       = cmdDisable ? '0 : w_req_raw;

    // Fixed priority always searches from channel 0 but leaves the rotation pointer alone.
    assign w_search    = cmdRotate ? r_ptr : 2'd0;
    assign w_winner    = f_pick(w_eff, w_search);
    assign w_winner_oh = {{(NCH-1){1'b0}}, 1'b1} << w_winner;
    assign w_active_oh = {{(NCH-1){1'b0}}, 1'b1} << r_active;

    // Register FSM state and every registered output together.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= IDLE;
            r_vdreq  <= '0;
            r_dack   <= '0;
            r_clr    <= '0;
            r_active <= 2'd0;
            r_ptr    <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_vdreq  <= w_vdreq_nxt;
            r_dack   <= w_dack_nxt;
            r_clr    <= w_clr_nxt;
            r_active <= w_active_nxt;
            r_ptr    <= w_ptr_nxt;
        end
    end

    // Next-state and next-output decode; clrReq is a pulse so it defaults to zero every cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_vdreq_nxt  = r_vdreq;
        w_dack_nxt   = r_dack;
        w_clr_nxt    = '0;
        w_active_nxt = r_active;
        w_ptr_nxt    = r_ptr;
        case (r_state)
            IDLE: begin
                if (|w_eff) begin
                    w_vdreq_nxt  = w_winner_oh;
                    w_active_nxt = w_winner;
                    w_state_nxt  = GRANT;
                end
            end
            GRANT: begin
                // Abort takes effect even if the acknowledge strobe arrives in the same cycle.
                if (!EOP_N) begin
                    w_vdreq_nxt = '0;
                    w_clr_nxt   = w_active_oh;
                    w_state_nxt = IDLE;
                end else if (validDACK) begin
                    // Acknowledge beats a request drop seen in the same cycle.
                    w_dack_nxt  = w_active_oh;
                    w_state_nxt = SERVICE;
                end else if (!w_req_raw[r_active]) begin
                    // Withdrawal: cmdDisable alone must not look like a dropped request,
                    // so this test uses the request term before the disable gate.
                    w_vdreq_nxt = '0;
                    w_state_nxt = IDLE;
                end
            end
            SERVICE: begin
                // serviceDone and EOP together are one completion.
                if (serviceDone || !EOP_N) begin
                    w_vdreq_nxt = '0;
                    w_dack_nxt  = '0;
                    w_clr_nxt   = w_active_oh;
                    w_state_nxt = IDLE;
                    if (cmdRotate) begin
                        w_ptr_nxt = r_active + 2'd1;
                    end
                end
            end
            default: begin
                w_vdreq_nxt = '0;
                w_dack_nxt  = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign VALID_DREQ = r_vdreq;
    assign clrReq     = r_clr;
    assign activeCh   = r_active;
    // Pin polarity follows the command bit immediately, including while in reset.
    assign DACK       = cmdDackHigh ? r_dack : ~r_dack;

endmodule

// File: tb/tb_dma_priority_encoder.sv
// Purpose: directed scoreboard bench for dma_priority_encoder.
// Latency: expected output snapshots carry the clock on which they must appear.
// Backpressure: none; the driver sequences validDACK/serviceDone/EOP_N itself.
module tb_dma_priority_encoder;

    logic       CLK;
    logic       RESET_N;
    logic [3:0] DREQ;
    logic [3:0] maskReg;
    logic [3:0] requestReg;
    logic       cmdDisable;
    logic       cmdRotate;
    logic       cmdDreqLow;
    logic       cmdDackHigh;
    logic       validDACK;
    logic       serviceDone;
    logic       EOP_N;
    logic [3:0] VALID_DREQ;
    logic [3:0] DACK;
    logic [1:0] activeCh;
    logic [3:0] clrReq;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  vd;
        logic [3:0]  dack;
        logic [3:0]  clr;
        logic [1:0]  act;
    } snap_t;

    snap_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;

    dma_priority_encoder #(.SYNC_STAGES(2), .NCH(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .maskReg(maskReg),
        .requestReg(requestReg), .cmdDisable(cmdDisable), .cmdRotate(cmdRotate),
        .cmdDreqLow(cmdDreqLow), .cmdDackHigh(cmdDackHigh), .validDACK(validDACK),
        .serviceDone(serviceDone), .EOP_N(EOP_N), .VALID_DREQ(VALID_DREQ),
        .DACK(DACK), .activeCh(activeCh), .clrReq(clrReq)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] oh(input logic [1:0] ch);
        logic [3:0] one;
        one = 4'b0001;
        return one << ch;
    endfunction

    function automatic logic [3:0] pin(input logic [3:0] act_hi);
        return cmdDackHigh ? act_hi : ~act_hi;
    endfunction

    task automatic expect_at(input int c, input logic [3:0] vd, input logic [3:0] dk,
                             input logic [3:0] cl, input logic [1:0] ac);
        snap_t s;
        s.cyc = 32'(c); s.vd = vd; s.dack = dk; s.clr = cl; s.act = ac;
        exp_q.push_back(s);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Monitor: whenever the visible outputs change, pop the next expected snapshot and compare.
    logic [13:0] prev_out = {4'b0000, 4'b1111, 4'b0000, 2'd0};
    always @(posedge CLK) begin
        logic [13:0] cur_out;
        snap_t       got;
        snap_t       want;
        #1;
        cur_out = {VALID_DREQ, DACK, clrReq, activeCh};
        if (cur_out != prev_out) begin
            got = {32'(cyc), cur_out};
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_change: got cyc=%0d vd=%b dack=%b clr=%b act=%0d, expected no change",
                         cyc, VALID_DREQ, DACK, clrReq, activeCh);
            end else begin
                want = exp_q.pop_front();
                n_tests++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL snapshot: got cyc=%0d vd=%b dack=%b clr=%b act=%0d, expected cyc=%0d vd=%b dack=%b clr=%b act=%0d",
                             got.cyc, got.vd, got.dack, got.clr, got.act,
                             want.cyc, want.vd, want.dack, want.clr, want.act);
                end
            end
        end
        prev_out = cur_out;
        chk("onehot_valid_dreq", 32'($onehot0(VALID_DREQ)), 32'd1);
        chk("onehot_dack", 32'($onehot0(cmdDackHigh ? DACK : ~DACK)), 32'd1);
    end

    // Acknowledge, serve and complete channel ch (granted now); DREQ takes dreq_after at acknowledge.
    task automatic do_service(input logic [1:0] ch, input logic [3:0] dreq_after,
                              input logic nxt_vld, input logic [1:0] nxt_ch);
        int c;
        c         = cyc;
        validDACK = 1'b1;
        DREQ      = dreq_after;
        expect_at(c + 1, oh(ch), pin(oh(ch)), 4'b0000, ch);
        tick(1);
        validDACK = 1'b0;
        tick(1);
        serviceDone = 1'b1;
        expect_at(c + 3, 4'b0000, pin(4'b0000), oh(ch), ch);
        tick(1);
        serviceDone = 1'b0;
        requestReg  = requestReg & ~oh(ch);
        if (nxt_vld) expect_at(c + 4, oh(nxt_ch), pin(4'b0000), 4'b0000, nxt_ch);
        else         expect_at(c + 4, 4'b0000, pin(4'b0000), 4'b0000, ch);
        tick(1);
    endtask

    initial begin
        int c;
        RESET_N = 1'b0; DREQ = '0; maskReg = '0; requestReg = '0;
        cmdDisable = 1'b0; cmdRotate = 1'b0; cmdDreqLow = 1'b0; cmdDackHigh = 1'b0;
        validDACK = 1'b0; serviceDone = 1'b0; EOP_N = 1'b1;
        #2;
        chk("reset_valid_dreq", 32'(VALID_DREQ), 32'h0);
        chk("reset_dack", 32'(DACK), 32'hF);
        chk("reset_clrreq", 32'(clrReq), 32'h0);
        chk("reset_activech", 32'(activeCh), 32'h0);
        tick(1);
        RESET_N = 1'b1;
        tick(1);

        // Fixed priority: ch1 beats ch3, then ch3 after ch1 completes.
        c = cyc; DREQ = 4'b1010;
        expect_at(c + 3, 4'b0010, 4'b1111, 4'b0000, 2'd1);
        tick(3);
        do_service(2'd1, 4'b1000, 1'b1, 2'd3);
        do_service(2'd3, 4'b0000, 1'b0, 2'd0);
        tick(2);

        // Rotating priority with all four requesting.
        cmdRotate = 1'b1;
        c = cyc; DREQ = 4'b1111;
        expect_at(c + 3, 4'b0001, 4'b1111, 4'b0000, 2'd0);
        tick(3);
        do_service(2'd0, 4'b1111, 1'b1, 2'd1);
        do_service(2'd1, 4'b1111, 1'b1, 2'd2);
        do_service(2'd2, 4'b1111, 1'b1, 2'd3);
        do_service(2'd3, 4'b1111, 1'b1, 2'd0);
        do_service(2'd0, 4'b0000, 1'b0, 2'd0);
        tick(2);

        // Withdrawal in GRANT: no clrReq, pointer stays at 1 so ch1 wins next.
        c = cyc; DREQ = 4'b0100;
        expect_at(c + 3, 4'b0100, 4'b1111, 4'b0000, 2'd2);
        tick(3);
        c = cyc; DREQ = 4'b0000;
        expect_at(c + 3, 4'b0000, 4'b1111, 4'b0000, 2'd2);
        tick(3);
        c = cyc; DREQ = 4'b1111;
        expect_at(c + 3, 4'b0010, 4'b1111, 4'b0000, 2'd1);
        tick(3);
        do_service(2'd1, 4'b0000, 1'b0, 2'd0);
        cmdRotate = 1'b0;
        tick(2);

        // Mask and active-low sense: only ch0 would be active, and it is masked.
        cmdDisable = 1'b1; cmdDreqLow = 1'b1; maskReg = 4'b0001; DREQ = 4'b1110;
        tick(3);
        cmdDisable = 1'b0;
        tick(5);
        chk("masked_no_grant", 32'(VALID_DREQ), 32'h0);
        c = cyc; requestReg = 4'b0001;
        expect_at(c + 1, 4'b0001, 4'b1111, 4'b0000, 2'd0);
        tick(1);
        do_service(2'd0, 4'b1110, 1'b0, 2'd0);
        cmdDisable = 1'b1; cmdDreqLow = 1'b0; maskReg = 4'b0000; DREQ = 4'b0000;
        tick(3);
        cmdDisable = 1'b0;
        tick(2);

        // EOP abort during SERVICE of ch3.
        c = cyc; DREQ = 4'b1000;
        expect_at(c + 3, 4'b1000, 4'b1111, 4'b0000, 2'd3);
        tick(3);
        c = cyc; validDACK = 1'b1; DREQ = 4'b0000;
        expect_at(c + 1, 4'b1000, 4'b0111, 4'b0000, 2'd3);
        tick(1);
        validDACK = 1'b0;
        tick(1);
        c = cyc; EOP_N = 1'b0;
        expect_at(c + 1, 4'b0000, 4'b1111, 4'b1000, 2'd3);
        tick(1);
        EOP_N = 1'b1;
        expect_at(c + 2, 4'b0000, 4'b1111, 4'b0000, 2'd3);
        tick(3);

        // Reset mid-SERVICE with active-high DACK; pointer must return to 0.
        c = cyc; cmdDackHigh = 1'b1;
        expect_at(c + 1, 4'b0000, 4'b0000, 4'b0000, 2'd3);
        tick(1);
        cmdRotate = 1'b1;
        c = cyc; DREQ = 4'b0100;
        expect_at(c + 3, 4'b0100, 4'b0000, 4'b0000, 2'd2);
        tick(3);
        c = cyc; validDACK = 1'b1; DREQ = 4'b0000;
        expect_at(c + 1, 4'b0100, 4'b0100, 4'b0000, 2'd2);
        tick(1);
        validDACK = 1'b0;
        tick(1);
        c = cyc;
        expect_at(c + 1, 4'b0000, 4'b0000, 4'b0000, 2'd0);
        RESET_N = 1'b0;
        #1;
        chk("async_reset_dack", 32'(DACK), 32'h0);
        chk("async_reset_valid_dreq", 32'(VALID_DREQ), 32'h0);
        chk("async_reset_activech", 32'(activeCh), 32'h0);
        tick(2);
        RESET_N = 1'b1;
        tick(1);
        c = cyc; DREQ = 4'b1111;
        expect_at(c + 3, 4'b0001, 4'b0000, 4'b0000, 2'd0);
        tick(3);
        do_service(2'd0, 4'b0000, 1'b0, 2'd0);
        tick(4);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_priority_encoder.md
Name: dma_priority_encoder

Overview:
- Request-arbitration stage directly upstream of the 8237A timing-control FSM.
- Synchronises the four DREQ pins and applies DREQ sense polarity, mask bits and software request bits.
- Picks one channel by fixed or rotating priority and presents it to the timing FSM as one-hot VALID_DREQ.
- Drives the external DACK pins from the FSM's validDACK strobe until the service cycle ends, then updates the rotation.

Parameters:
- SYNC_STAGES, 2: flop stages on each DREQ pin before arbitration; legal values are 1 or more.
- NCH, 4: channel count; only 4 is supported, and all 4-bit vectors below use it.

Ports:
- CLK, in, 1: system clock; all state updates on the rising edge.
- RESET_N, in, 1: asynchronous, active-low reset.
- DREQ, in, 4: external DMA request pins, asynchronous to CLK.
- maskReg, in, 4: per-channel mask; 1 blocks the hardware DREQ.
- requestReg, in, 4: software request bits; they ignore mask and sense.
- cmdDisable, in, 1: commandReg[2]; 1 disables all arbitration.
- cmdRotate, in, 1: commandReg[4]; 1 selects rotating priority, 0 selects fixed priority.
- cmdDreqLow, in, 1: commandReg[6]; 1 makes DREQ active-low.
- cmdDackHigh, in, 1: commandReg[7]; 1 makes DACK active-high.
- validDACK, in, 1: one-cycle strobe from the timing FSM in S1.
- serviceDone, in, 1: one-cycle strobe from the timing FSM in S4.
- EOP_N, in, 1: external end-of-process, active-low.
- VALID_DREQ, out, 4: one-hot granted request to the timing FSM.
- DACK, out, 4: DMA acknowledge pins, polarity set by cmdDackHigh.
- activeCh, out, 2: encoded index of the granted channel.
- clrReq, out, 4: one-cycle pulse telling the register file to clear requestReg bits.

Behaviour:
- Reset values:
  - VALID_DREQ=0, clrReq=0, activeCh=0.
  - DACK = all inactive: 4'b1111 when cmdDackHigh=0, 4'b0000 when cmdDackHigh=1. DACK polarity tracks cmdDackHigh combinationally.
  - Priority pointer = 0, so channel 0 is highest.
  - Synchroniser flops = 0. State = IDLE.
- Effective request:
  - eff = ((dreqSync ^ {4{cmdDreqLow}}) & ~maskReg) | requestReg.
  - eff is forced to 0 while cmdDisable=1.
- Priority order:
  - Fixed: 0 > 1 > 2 > 3.
  - Rotating: search starts at channel ptr; after a channel completes service, ptr = (winner+1) mod 4, so the winner becomes lowest priority.
  - cmdRotate=0 forces the search start to 0 but leaves ptr unchanged.
- FSM states: IDLE, GRANT, SERVICE.
- IDLE:
  - If eff≠0: register the winner into VALID_DREQ (one-hot) and activeCh, then go to GRANT.
  - Latency from DREQ pin edge to VALID_DREQ is SYNC_STAGES+1 clocks; requestReg skips the synchroniser, so its latency is 1 clock.
- GRANT:
  - VALID_DREQ is held stable. Requests from other channels are ignored, with no preemption.
  - validDACK=1: assert DACK[activeCh] active on the next edge, go to SERVICE.
  - eff[activeCh] drops before validDACK: clear VALID_DREQ and return to IDLE. No clrReq is issued and ptr is unchanged.
  - EOP_N=0: clear VALID_DREQ, go to IDLE, pulse clrReq[activeCh]. ptr is unchanged.
- SERVICE:
  - DACK[activeCh] and VALID_DREQ stay asserted; DREQ changes are ignored.
  - serviceDone=1 or EOP_N=0 in the same cycle:
    - DACK returns inactive and VALID_DREQ=0.
    - Pulse clrReq[activeCh] for one cycle.
    - If cmdRotate=1, update ptr.
    - Go to IDLE.
  - A new arbitration can start in the cycle after IDLE is re-entered.
- Simultaneous events:
  - validDACK together with a DREQ drop in GRANT: validDACK wins and the block enters SERVICE.
  - serviceDone together with EOP_N=0: treated as a single completion.
- cmdDisable=1 while in GRANT or SERVICE: the current transfer completes normally; only new arbitration is blocked.
- Asserting RESET_N low mid-transfer returns all state and outputs to their reset values immediately.
- At most one bit of VALID_DREQ or DACK is active at any time; the bench asserts this.

Test Plan:
- Fixed priority: cmdRotate=0, DREQ=4'b1010 → VALID_DREQ=4'b0010 three clocks later; after validDACK, DACK=4'b1101; serviceDone → DACK=4'b1111 and clrReq=4'b0010 pulse; then VALID_DREQ=4'b1000.
- Rotating priority: cmdRotate=1, DREQ=4'b1111 held, four services complete → grant order ch0, ch1, ch2, ch3, then ch0 again.
- Mask and sense: maskReg=4'b0001, cmdDreqLow=1, DREQ=4'b1110 → no grant. requestReg=4'b0001 → VALID_DREQ=4'b0001 after 1 clock.
- Withdrawal: DREQ[2] drops while in GRANT before validDACK → VALID_DREQ=0, no clrReq, back to IDLE, ptr unchanged.
- EOP abort: EOP_N=0 in SERVICE for ch3 → DACK inactive next clock, clrReq=4'b1000, IDLE.
- Reset mid-SERVICE with cmdDackHigh=1: RESET_N low → DACK=4'b0000, VALID_DREQ=0 asynchronously; ptr=0 after release.
